// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive path. Recovers one asynchronous character per
// frame (start, 7/8 data bits LSB first, optional parity, one stop bit) and
// presents it to the host with ready/parity/framing/overrun status.
//
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   rx     - asynchronous serial line, idle high
//   k      - clocks per bit time (4 .. 2^20-1)
//   eight  - 1: 8 data bits, 0: 7 data bits
//   pen    - 1: parity bit present
//   ohel   - 1: odd parity, 0: even parity
//   read   - one-clock pulse, host consumed data
//   data   - received character (bit 7 = 0 in 7-bit mode)
//   rxrdy  - character available
//   perr   - parity error on last frame
//   ferr   - framing error on last frame
//   ovf    - overrun: frame completed while rxrdy still set
module uart_rx_frame (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [19:0] k,
  input  logic        eight,
  input  logic        pen,
  input  logic        ohel,
  input  logic        read,
  output logic [7:0]  data,
  output logic        rxrdy,
  output logic        perr,
  output logic        ferr,
  output logic        ovf
);

  typedef enum logic [1:0] {StIdle, StStart, StData} state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [19:0] k_q, k_d;
  logic        eight_q, eight_d;
  logic        pen_q, pen_d;
  logic        ohel_q, ohel_d;
  logic [19:0] bt_q, bt_d;
  logic [3:0]  bi_q, bi_d;
  // Holds the samples taken so far; the sample being taken this cycle is
  // appended live, so {rx_s_q, sh_q} is the full right-shifted frame word.
  logic [8:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d;
  logic        rxrdy_q, rxrdy_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        ovf_q, ovf_d;

  logic        complete;
  logic [3:0]  last_bi;
  logic [9:0]  word;
  logic [7:0]  rx_data;
  logic        rx_par;
  logic        exp_par;

  // Index of the stop-bit sample: N-1 = 7 + eight + pen.
  assign last_bi = 4'd7 + {3'b000, eight_q} + {3'b000, pen_q};
  assign word    = {rx_s_q, sh_q};

  // After N shifts the frame occupies word[9:10-N]; stop is always word[9].
  always_comb begin
    rx_data = 8'h00;
    rx_par  = 1'b0;
    unique case ({eight_q, pen_q})
      2'b11: begin rx_data = word[7:0];          rx_par = word[8]; end
      2'b10: begin rx_data = word[8:1];          rx_par = 1'b0;    end
      2'b01: begin rx_data = {1'b0, word[7:1]};  rx_par = word[8]; end
      default: begin rx_data = {1'b0, word[8:2]}; rx_par = 1'b0;   end
    endcase
  end

  // Bit 7 of rx_data is 0 in 7-bit mode, so the reduction covers 7 or 8 bits.
  assign exp_par = (^rx_data) ^ ohel_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    eight_d  = eight_q;
    pen_d    = pen_q;
    ohel_d   = ohel_q;
    bt_d     = bt_q;
    bi_d     = bi_q;
    sh_d     = sh_q;
    complete = 1'b0;

    unique case (state_q)
      StIdle: begin
        bt_d = '0;
        bi_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
          k_d     = k;
          eight_d = eight;
          pen_d   = pen;
          ohel_d  = ohel;
        end
      end
      StStart: begin
        bt_d = bt_q + 20'd1;
        if (bt_q == (k_q >> 1) - 20'd1) begin
          bt_d    = '0;
          bi_d    = '0;
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        bt_d = bt_q + 20'd1;
        if (bt_q == k_q - 20'd1) begin
          bt_d = '0;
          bi_d = bi_q + 4'd1;
          sh_d = word[9:1];
          if (bi_q == last_bi) begin
            complete = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    rxrdy_d = rxrdy_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovf_d   = ovf_q;
    if (complete) begin
      // A read coinciding with completion consumed the old byte: no overrun.
      data_d  = rx_data;
      ferr_d  = ~rx_s_q;
      perr_d  = pen_q & (rx_par != exp_par);
      ovf_d   = rxrdy_q & ~read;
      rxrdy_d = 1'b1;
    end else if (read) begin
      rxrdy_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizer resets to line idle so no start is seen out of reset.
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      k_q       <= '0;
      eight_q   <= 1'b0;
      pen_q     <= 1'b0;
      ohel_q    <= 1'b0;
      bt_q      <= '0;
      bi_q      <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      rxrdy_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      k_q       <= k_d;
      eight_q   <= eight_d;
      pen_q     <= pen_d;
      ohel_q    <= ohel_d;
      bt_q      <= bt_d;
      bi_q      <= bi_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      rxrdy_q   <= rxrdy_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign data  = data_q;
  assign rxrdy = rxrdy_q;
  assign perr  = perr_q;
  assign ferr  = ferr_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial receive path for the UART. Recovers one asynchronous character per frame from the line, using the same format controls as the transmit side: `eight` selects 8 or 7 data bits, `pen` enables parity, and `ohel` selects odd (1) or even (0) parity. It delivers the parallel byte plus status flags (ready, parity error, framing error, overrun) to the host interface. The block sits between the pad-side RX line and the host register/read logic.

## Interface
- No parameters; bit time is a run-time input.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `rx`  in  1  asynchronous serial line; idle high
- `k`  in  20  clocks per bit time; legal range 4..2^20-1
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits
- `pen`  in  1  1 = parity bit present
- `ohel`  in  1  1 = odd parity, 0 = even parity
- `read`  in  1  one-clock pulse; host has consumed `data`
- `data`  out  8  received character, LSB = first data bit; bit 7 = 0 in 7-bit mode
- `rxrdy`  out  1  character available
- `perr`  out  1  parity error on last frame
- `ferr`  out  1  framing error (stop bit sampled low) on last frame
- `ovf`  out  1  overrun: a frame completed while `rxrdy` was still set

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`. All decisions use `rx_s`.
- Frame on the line: start (0), 7 or 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- N = samples after start = 7 + `eight` + `pen` + 1. N is 8, 9 or 10.
- `k`, `eight`, `pen` and `ohel` are latched on the IDLE→START transition. Changes mid-frame have no effect on the frame in progress.
- State machine:
  - IDLE: clear bit-time counter `bt` and bit index `bi`. If `rx_s`==0, go to START.
  - START: increment `bt`. When `bt` == (k>>1)-1: if `rx_s`==0, go to DATA with `bt`=0, `bi`=0. Otherwise (false start) go to IDLE.
  - DATA: increment `bt`. When `bt` == k-1, sample `rx_s` into a 10-bit right shift register (new bit enters at bit 9), then `bt`=0 and `bi`++.
  - DATA, sample with `bi` == N-1: this is the stop bit. Update outputs and go to IDLE.
- Output update at stop sample:
  - `data` = received data bits.
  - `ferr` = ~stop.
  - `perr` = `pen` & (received parity != expected parity). Expected parity is ^data for even and ~^data for odd, taken over 7 or 8 bits per `eight`. `perr` = 0 when `pen`=0.
  - `ovf` = `rxrdy` & ~`read`.
  - `rxrdy` = 1.
- `read` in a cycle with no completion: `rxrdy`←0 and `ovf`←0. `data`, `perr` and `ferr` hold.
- Completion and `read` in the same cycle: the completion wins. `rxrdy`=1 and `ovf`=0, because the old byte counts as consumed.
- A frame with `ferr`=1 still sets `rxrdy` and still loads `data`.
- A stop bit sampled low returns to IDLE immediately. The next start is detected as soon as `rx_s` is 0.
- `reset` forces IDLE, clears the counters and the shift register, and sets all outputs to 0. Reset mid-frame discards the partial frame.

## Timing
- Synchronizer latency: 2 clocks from `rx` edge to `rx_s`.
- Start validation happens k>>1 clocks after IDLE sees `rx_s` low. Each later sample is k clocks after the previous one, so sampling lands near mid-bit.
- Outputs are registered. They change on the clock edge that samples the stop bit, which is (k>>1) + N·k clocks after start detection.
- Reset values: `data`=0, `rxrdy`=0, `perr`=0, `ferr`=0, `ovf`=0.
- Throughput: back-to-back frames with zero idle time are received without loss.

## Test plan
- 8N1 reception: k=16, `eight`=1, `pen`=0, send 0xA5 → `rxrdy`=1 exactly 8+9·16 clocks after start detection, `data`=0xA5, `perr`=`ferr`=`ovf`=0. Then pulse `read` → `rxrdy`=0 on the next edge.
- Parity check: 7 data bits, even parity (`eight`=0, `pen`=1, `ohel`=0), k=16, send 0x41 with parity bit 0 → `data`=0x41, `perr`=0. Resend with parity bit 1 → `perr`=1. Switch to odd parity (`ohel`=1) with parity bit 1 → `perr`=0.
- False start: k=16, drive `rx` low for 4 clocks, then high → the block returns to IDLE and `rxrdy` stays 0. A valid 0x3C frame sent immediately afterwards is received correctly.
- Framing error: 8N1, send 0xFF with the stop bit driven 0 → `ferr`=1, `rxrdy`=1, `data`=0xFF. A following good frame clears `ferr`.
- Overrun and read race: receive two frames back-to-back with no `read` → second completion gives `ovf`=1, `data`=second byte. Repeat with `read` asserted on the exact completion cycle → `ovf`=0, `rxrdy`=1.
- Reset mid-frame: assert `reset` for 1 clock halfway through a frame → all outputs 0. Then send 0x5A cleanly → `data`=0x5A with no spurious `ferr`.
